// File: rtl/cpu_pkg.sv
// Shared CPU constants: data width and the RegZ/RegY/RegX/ALU control encodings.
// Control and result_collector both import this package so they agree on tz values.
package cpu_pkg;

    localparam int unsigned DATA_W = 4;
    localparam int unsigned CTRL_W = 4;

    // RegZ control word (tz)
    localparam logic [CTRL_W-1:0] TZ_HOLD  = 4'b0000;
    localparam logic [CTRL_W-1:0] TZ_LOAD  = 4'b0001;  // RegZ loads acumulador this edge
    localparam logic [CTRL_W-1:0] TZ_CLEAR = 4'b0010;

    // RegY control word (ty)
    localparam logic [CTRL_W-1:0] TY_HOLD  = 4'b0000;
    localparam logic [CTRL_W-1:0] TY_LOAD  = 4'b0001;
    localparam logic [CTRL_W-1:0] TY_CLEAR = 4'b0010;

    // RegX control word (tx)
    localparam logic [CTRL_W-1:0] TX_HOLD  = 4'b0000;
    localparam logic [CTRL_W-1:0] TX_LOAD  = 4'b0001;
    localparam logic [CTRL_W-1:0] TX_CLEAR = 4'b0010;

    // ALU operation (tula)
    localparam logic [CTRL_W-1:0] TULA_ADD = 4'b0000;
    localparam logic [CTRL_W-1:0] TULA_SUB = 4'b0001;
    localparam logic [CTRL_W-1:0] TULA_AND = 4'b0010;
    localparam logic [CTRL_W-1:0] TULA_OR  = 4'b0011;

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO with synchronous clear.
// Ports: clock, reset (async high), clear, push/wr_data, pop,
//        rd_valid/rd_data (head, 0 when empty), count/full/empty.
// A push while full is accepted only if a pop happens on the same edge;
// a pop while empty is ignored. clear dominates push and pop.
module sync_fifo #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic                     rd_valid,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    // Next-state: pointers wrap naturally because DEPTH is a power of two
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_pop   = pop && (count_q != '0);
        do_push  = push && ((count_q != CNT_W'(DEPTH)) || do_pop);
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = wr_data;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Status and head are decoded from flops only; no path from pop
    assign empty    = (count_q == '0);
    assign full     = (count_q == CNT_W'(DEPTH));
    assign rd_valid = !empty;
    assign rd_data  = empty ? '0 : mem_q[rd_ptr_q];
    assign count    = count_q;

endmodule

// File: rtl/result_collector.sv
// Captures every value the CPU stores into RegZ and queues it for a consumer.
// Ports: clock, reset (async high), tz/cpu_out (CPU RegZ control and output),
//        clear (sync flush), rd_ready/rd_valid/rd_data (show-ahead drain),
//        count/full/empty (FIFO status), overflow (sticky drop flag).
// RegZ loads on the edge tz is sampled, so the capture happens one edge later.
module result_collector
    import cpu_pkg::*;
#(
    parameter int unsigned         WIDTH   = DATA_W,
    parameter int unsigned         DEPTH   = 8,
    parameter logic [CTRL_W-1:0]   TZ_LOAD = cpu_pkg::TZ_LOAD
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [CTRL_W-1:0]        tz,
    input  logic [WIDTH-1:0]         cpu_out,
    input  logic                     clear,
    input  logic                     rd_ready,
    output logic                     rd_valid,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic                     overflow
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_ARMED = 1'b1;

    logic [0:0] state_q, state_d;
    logic       overflow_q, overflow_d;
    logic       push_c;
    logic       pop_c;

    assign pop_c = rd_valid && rd_ready;

    // Capture FSM and sticky overflow; clear discards a pending capture
    always_comb begin
        state_d    = ST_IDLE;
        overflow_d = overflow_q;
        push_c     = 1'b0;
        if (clear) begin
            overflow_d = 1'b0;
        end else begin
            if (tz == TZ_LOAD) begin
                state_d = ST_ARMED;
            end
            push_c = (state_q == ST_ARMED);
            // Full push is dropped unless the head leaves on the same edge
            if (push_c && full && !pop_c) begin
                overflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            overflow_q <= overflow_d;
        end
    end

    assign overflow = overflow_q;

    sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock    (clock),
        .reset    (reset),
        .clear    (clear),
        .push     (push_c),
        .wr_data  (cpu_out),
        .pop      (pop_c),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .count    (count),
        .full     (full),
        .empty    (empty)
    );

endmodule

// File: tb/tb_result_collector.sv
// Directed bench for result_collector: single capture, back-to-back loads,
// fill/overflow, full with simultaneous pop, pointer wrap, clear and async reset.
module tb_result_collector;

    logic       clock;
    logic       reset;
    logic [3:0] tz;
    logic [3:0] cpu_out;
    logic       clear;
    logic       rd_ready;
    logic       rd_valid;
    logic [3:0] rd_data;
    logic [3:0] count;
    logic       full;
    logic       empty;
    logic       overflow;

    int n_checks;
    int n_fail;

    result_collector #(
        .WIDTH   (4),
        .DEPTH   (8),
        .TZ_LOAD (4'b0001)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .tz       (tz),
        .cpu_out  (cpu_out),
        .clear    (clear),
        .rd_ready (rd_ready),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .count    (count),
        .full     (full),
        .empty    (empty),
        .overflow (overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, advance past the edge, settle
    task automatic cyc(input logic [3:0] tz_v, input logic [3:0] out_v,
                       input logic rdy_v, input logic clr_v);
        tz       = tz_v;
        cpu_out  = out_v;
        rd_ready = rdy_v;
        clear    = clr_v;
        @(posedge clock);
        #1;
    endtask

    // One RegZ store of v: tz pulse, then v on the bus during the capture cycle
    task automatic capture(input logic [3:0] v, input logic rdy_on_push);
        cyc(4'b0001, 4'h0, 1'b0, 1'b0);
        cyc(4'b0000, v, rdy_on_push, 1'b0);
    endtask

    logic [3:0] exp_q[$];
    logic [3:0] v;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        tz       = 4'h0;
        cpu_out  = 4'h0;
        clear    = 1'b0;
        rd_ready = 1'b0;
        reset    = 1'b1;
        #23;
        reset = 1'b0;
        @(posedge clock);
        #1;

        // Reset state
        check("rst_valid", 32'(rd_valid), 32'd0);
        check("rst_data",  32'(rd_data),  32'd0);
        check("rst_count", 32'(count),    32'd0);
        check("rst_empty", 32'(empty),    32'd1);
        check("rst_full",  32'(full),     32'd0);
        check("rst_ovf",   32'(overflow), 32'd0);

        // Single capture: tz at edge N, value written at N+1
        cyc(4'b0001, 4'h0, 1'b0, 1'b0);
        check("single_not_yet", 32'(rd_valid), 32'd0);
        cyc(4'b0000, 4'hA, 1'b0, 1'b0);
        check("single_valid", 32'(rd_valid), 32'd1);
        check("single_data",  32'(rd_data),  32'hA);
        check("single_count", 32'(count),    32'd1);
        cyc(4'b0000, 4'h0, 1'b1, 1'b0);
        check("single_empty", 32'(empty),   32'd1);
        check("single_zero",  32'(rd_data), 32'd0);

        // Back-to-back loads
        cyc(4'b0001, 4'h0, 1'b0, 1'b0);
        cyc(4'b0001, 4'h3, 1'b0, 1'b0);
        cyc(4'b0001, 4'h5, 1'b0, 1'b0);
        cyc(4'b0000, 4'h7, 1'b0, 1'b0);
        check("b2b_count", 32'(count), 32'd3);
        check("b2b_d0", 32'(rd_data), 32'h3);
        cyc(4'b0000, 4'h0, 1'b1, 1'b0);
        check("b2b_d1", 32'(rd_data), 32'h5);
        cyc(4'b0000, 4'h0, 1'b1, 1'b0);
        check("b2b_d2", 32'(rd_data), 32'h7);
        cyc(4'b0000, 4'h0, 1'b1, 1'b0);
        check("b2b_empty", 32'(empty), 32'd1);

        // Fill to full with 1..8
        for (int i = 1; i <= 8; i++) begin
            capture(4'(i), 1'b0);
        end
        check("fill_full",  32'(full),     32'd1);
        check("fill_count", 32'(count),    32'd8);
        check("fill_ovf0",  32'(overflow), 32'd0);

        // Full with simultaneous pop: head 1 leaves, C enters
        capture(4'hC, 1'b1);
        check("fpop_count", 32'(count),    32'd8);
        check("fpop_ovf",   32'(overflow), 32'd0);
        check("fpop_head",  32'(rd_data),  32'h2);

        // Ninth-style capture while full with no pop: dropped
        capture(4'h9, 1'b0);
        check("ovf_set",   32'(overflow), 32'd1);
        check("ovf_count", 32'(count),    32'd8);

        // Drain: 2..8 then C; overflow sticky
        for (int i = 2; i <= 8; i++) begin
            check($sformatf("drain_%0d", i), 32'(rd_data), 32'(i));
            cyc(4'b0000, 4'h0, 1'b1, 1'b0);
        end
        check("drain_C", 32'(rd_data), 32'hC);
        cyc(4'b0000, 4'h0, 1'b1, 1'b0);
        check("drain_empty", 32'(empty),    32'd1);
        check("ovf_sticky",  32'(overflow), 32'd1);
        cyc(4'b0000, 4'h0, 1'b0, 1'b1);
        check("ovf_cleared", 32'(overflow), 32'd0);

        // Wrap-around: 20 captures with interleaved pops, scoreboarded
        exp_q.delete();
        for (int i = 0; i < 20; i++) begin
            logic rdy;
            v   = 4'((i * 7 + 3) & 15);
            rdy = (i % 3) != 0;
            // tz cycle
            check($sformatf("wrap_valid_a%0d", i), 32'(rd_valid), 32'(exp_q.size() != 0));
            if (exp_q.size() != 0) check($sformatf("wrap_data_a%0d", i), 32'(rd_data), 32'(exp_q[0]));
            if (rdy && exp_q.size() != 0) void'(exp_q.pop_front());
            cyc(4'b0001, 4'h0, rdy, 1'b0);
            // capture cycle
            if (exp_q.size() != 0) check($sformatf("wrap_data_b%0d", i), 32'(rd_data), 32'(exp_q[0]));
            if (rdy && exp_q.size() != 0) void'(exp_q.pop_front());
            cyc(4'b0000, v, rdy, 1'b0);
            exp_q.push_back(v);
            check($sformatf("wrap_count%0d", i), 32'(count), 32'(exp_q.size()));
        end
        while (exp_q.size() != 0) begin
            check("wrap_tail", 32'(rd_data), 32'(exp_q[0]));
            void'(exp_q.pop_front());
            cyc(4'b0000, 4'h0, 1'b1, 1'b0);
        end
        check("wrap_empty", 32'(empty), 32'd1);

        // Clear while a capture is pending, with an older entry present
        capture(4'h5, 1'b0);
        cyc(4'b0001, 4'h0, 1'b0, 1'b0);
        cyc(4'b0000, 4'hD, 1'b0, 1'b1);
        cyc(4'b0000, 4'h0, 1'b0, 1'b0);
        check("clr_empty", 32'(empty),    32'd1);
        check("clr_count", 32'(count),    32'd0);
        check("clr_ovf",   32'(overflow), 32'd0);

        // Async reset between edges while armed
        capture(4'h6, 1'b0);
        cyc(4'b0001, 4'h0, 1'b0, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        check("arst_valid", 32'(rd_valid), 32'd0);
        check("arst_count", 32'(count),    32'd0);
        check("arst_data",  32'(rd_data),  32'd0);
        tz      = 4'h0;
        cpu_out = 4'h9;
        @(posedge clock);
        #2;
        reset = 1'b0;
        @(posedge clock);
        #1;
        check("arst_lost", 32'(empty), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
